// File: rtl/track_cmd_gen.sv
// Line-following command generator: turns the edge-section vector into a steering
// command and streams it as a {"T":1,"L":a,"R":b}\n ASCII frame to a UART transmitter.
module track_cmd_gen #(
  parameter int unsigned N_SECTIONS = 18,
  parameter int unsigned DEADZONE   = 3,
  parameter int unsigned MIN_SPEED  = 5,
  parameter int unsigned STEP       = 1,
  parameter int unsigned MAX_SPEED  = 20,
  parameter int unsigned PERIOD     = 5_000_000,
  parameter int unsigned LOST_LIMIT = 3,
  parameter int unsigned ON_CHANGE  = 1,
  parameter int unsigned HOLDOFF    = 500_000
) (
  input  logic                  clk_50,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [N_SECTIONS-1:0] sections,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic [1:0]            cmd_dir,
  output logic [6:0]            cmd_speed,
  output logic [15:0]           frames_sent
);

  localparam int unsigned IW     = (N_SECTIONS > 1) ? $clog2(N_SECTIONS) : 1;
  localparam int unsigned CENTER = N_SECTIONS / 2;
  localparam int unsigned PW     = $clog2(PERIOD + 1);
  localparam int unsigned HW     = $clog2(HOLDOFF + 2);
  localparam int unsigned LW     = $clog2(LOST_LIMIT + 2);

  localparam logic [1:0] DIR_STOP  = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_DONE} state_t;

  state_t          r_state;
  logic [PW-1:0]   r_per_cnt;
  logic [LW-1:0]   r_lost;
  logic [HW-1:0]   r_hold_cnt;
  logic            r_pending;
  logic [1:0]      r_tgt_dir;
  logic [6:0]      r_tgt_spd;
  logic [4:0]      r_slot;
  logic            r_a_neg;
  logic            r_b_neg;
  logic [3:0]      r_tens;
  logic [3:0]      r_units;

  logic            w_found;
  logic            w_empty;
  logic [IW-1:0]   w_idx;
  logic            w_pos;
  logic [31:0]     w_mag;
  logic [63:0]     w_raw;
  logic [1:0]      w_dir;
  logic [6:0]      w_speed;
  logic            w_tick;
  logic [LW-1:0]   w_lost_inc;
  logic            w_hold_ok;
  logic            w_change;
  logic            w_chg_start;
  logic [4:0]      w_next_slot;

  // Frame laid out as 28 canonical slots; slots 11 and 21 are the optional '-' signs.
  function automatic logic [7:0] slot_byte(input logic [4:0] s, input logic [3:0] t,
                                           input logic [3:0] u);
    logic [7:0] b;
    case (s)
      5'd0:                                  b = 8'h7B;
      5'd1, 5'd3, 5'd7, 5'd9, 5'd17, 5'd19:  b = 8'h22;
      5'd2:                                  b = 8'h54;
      5'd4, 5'd10, 5'd20:                    b = 8'h3A;
      5'd5:                                  b = 8'h31;
      5'd6, 5'd16:                           b = 8'h2C;
      5'd8:                                  b = 8'h4C;
      5'd18:                                 b = 8'h52;
      5'd11, 5'd21:                          b = 8'h2D;
      5'd12, 5'd22:                          b = 8'h30;
      5'd13, 5'd23:                          b = 8'h2E;
      5'd14, 5'd24:                          b = 8'h30 + {4'h0, t};
      5'd15, 5'd25:                          b = 8'h30 + {4'h0, u};
      5'd26:                                 b = 8'h7D;
      default:                               b = 8'h0A;
    endcase
    return b;
  endfunction

  always_comb begin
    w_idx   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < N_SECTIONS; i++) begin
      if (sections[i] && !w_found) begin
        w_idx   = IW'(i);
        w_found = 1'b1;
      end
    end
    w_empty = !w_found;
    w_pos   = (32'(w_idx) >= CENTER);
    w_mag   = w_pos ? (32'(w_idx) - CENTER) : (CENTER - 32'(w_idx));
    w_raw   = 64'(MIN_SPEED) + 64'(w_mag - DEADZONE - 1) * 64'(STEP);
    w_dir   = DIR_STOP;
    w_speed = '0;
    if (w_mag > DEADZONE) begin
      w_dir   = w_pos ? DIR_LEFT : DIR_RIGHT;
      w_speed = (w_raw > 64'(MAX_SPEED)) ? 7'(MAX_SPEED) : 7'(w_raw);
    end
  end

  always_comb begin
    w_tick      = (r_per_cnt == PW'(PERIOD - 1));
    w_lost_inc  = (r_lost >= LW'(LOST_LIMIT)) ? r_lost : r_lost + 1'b1;
    w_hold_ok   = (r_hold_cnt >= HW'(HOLDOFF));
    w_change    = (ON_CHANGE != 0) && !w_empty && w_hold_ok &&
                  ((w_dir != cmd_dir) || (w_speed != cmd_speed));
    w_chg_start = (r_state == S_IDLE) && enable && !w_tick && !r_pending && w_change;
    w_next_slot = r_slot + 5'd1;
    if ((w_next_slot == 5'd11) && !r_a_neg) w_next_slot = 5'd12;
    if ((w_next_slot == 5'd21) && !r_b_neg) w_next_slot = 5'd22;
  end

  always_ff @(posedge clk_50) begin
    if (!reset_n) r_per_cnt <= '0;
    else if (w_tick) r_per_cnt <= '0;
    else r_per_cnt <= r_per_cnt + 1'b1;
  end

  // Target command: refreshed on ticks, or directly when a change-triggered frame starts.
  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      r_lost    <= '0;
      r_tgt_dir <= DIR_STOP;
      r_tgt_spd <= '0;
    end else if (w_tick) begin
      if (!w_empty) begin
        r_lost    <= '0;
        r_tgt_dir <= w_dir;
        r_tgt_spd <= w_speed;
      end else begin
        r_lost <= w_lost_inc;
        if (w_lost_inc >= LW'(LOST_LIMIT)) begin
          r_tgt_dir <= DIR_STOP;
          r_tgt_spd <= '0;
        end
      end
    end else if (w_chg_start) begin
      r_tgt_dir <= w_dir;
      r_tgt_spd <= w_speed;
    end
  end

  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_pending   <= 1'b0;
      r_hold_cnt  <= HW'(HOLDOFF);
      r_slot      <= '0;
      r_a_neg     <= 1'b0;
      r_b_neg     <= 1'b0;
      r_tens      <= '0;
      r_units     <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      busy        <= 1'b0;
      cmd_dir     <= DIR_STOP;
      cmd_speed   <= '0;
      frames_sent <= '0;
    end else begin
      if (r_hold_cnt < HW'(HOLDOFF)) r_hold_cnt <= r_hold_cnt + 1'b1;
      if (w_tick && (r_state != S_IDLE)) r_pending <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (enable && (w_tick || r_pending || w_change)) begin
            r_state   <= S_LOAD;
            busy      <= 1'b1;
            r_pending <= 1'b0;
          end else if (!enable) begin
            r_pending <= 1'b0;
          end
        end
        S_LOAD: begin
          cmd_dir    <= r_tgt_dir;
          cmd_speed  <= r_tgt_spd;
          r_hold_cnt <= '0;
          r_a_neg    <= (r_tgt_dir == DIR_RIGHT);
          r_b_neg    <= (r_tgt_dir == DIR_LEFT);
          r_tens     <= 4'(r_tgt_spd / 7'd10);
          r_units    <= 4'(r_tgt_spd % 7'd10);
          r_slot     <= '0;
          tx_data    <= slot_byte(5'd0, 4'd0, 4'd0);
          tx_valid   <= 1'b1;
          r_state    <= S_SEND;
        end
        S_SEND: begin
          if (tx_valid && tx_ready) begin
            if (r_slot == 5'd27) begin
              tx_valid <= 1'b0;
              r_state  <= S_DONE;
            end else begin
              r_slot  <= w_next_slot;
              tx_data <= slot_byte(w_next_slot, r_tens, r_units);
            end
          end
        end
        default: begin
          frames_sent <= frames_sent + 16'd1;
          busy        <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
